// File: rtl/edge_detect_multi_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Optional feature macro: EDGE_DETECT_STICKY_EN (latched pulse flags).
package edge_detect_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic [3:0] {
    ST_LO     = 4'b0001,
    ST_CHK_HI = 4'b0010,
    ST_HI     = 4'b0100,
    ST_CHK_LO = 4'b1000
  } state_t;

  // Decides whether a committed edge of the given polarity should pulse.
  function automatic logic edge_en(input logic [1:0] mode, input logic is_rise);
    logic en;
    case (mode)
      MODE_RISE: en = is_rise;
      MODE_FALL: en = !is_rise;
      MODE_BOTH: en = 1'b1;
      MODE_OFF:  en = 1'b0;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
// Channel bus of the multi-channel edge detector.
// Optional feature macro: EDGE_DETECT_STICKY_EN adds i_clr / o_sticky.
interface edge_detect_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   i_sig;
  logic [2*CH-1:0] i_mode;
  logic [CH-1:0]   o_level;
  logic [CH-1:0]   o_pulse;
`ifdef EDGE_DETECT_STICKY_EN
  logic [CH-1:0]   i_clr;
  logic [CH-1:0]   o_sticky;
`endif

  modport master (
    output i_sig,
    output i_mode,
    input  o_level,
    input  o_pulse
`ifdef EDGE_DETECT_STICKY_EN
    ,
    output i_clr,
    input  o_sticky
`endif
  );

  modport slave (
    input  i_sig,
    input  i_mode,
    output o_level,
    output o_pulse
`ifdef EDGE_DETECT_STICKY_EN
    ,
    input  i_clr,
    output o_sticky
`endif
  );

endinterface

// File: rtl/edge_detect_multi_ch.sv
// One edge-detector channel: synchroniser, glitch-filter FSM, output registers.
// Optional feature macro: EDGE_DETECT_STICKY_EN adds the sticky pulse flag.
//
// state     | meaning
// ----------|----------------------------------------------------------
// ST_LO     | stable low committed, waiting for a high sample
// ST_CHK_HI | counting consecutive high samples before committing high
// ST_HI     | stable high committed, waiting for a low sample
// ST_CHK_LO | counting consecutive low samples before committing low
module edge_detect_ch
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sig,
  input  logic [1:0] i_mode,
  output logic       o_level,
  output logic       o_pulse
`ifdef EDGE_DETECT_STICKY_EN
  ,
  input  logic       i_clr,
  output logic       o_sticky
`endif
);

  localparam int            CW     = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILT_LEN);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [CW-1:0]          w_cnt_inc;
  logic                   w_s;
  logic                   w_commit_rise;
  logic                   w_commit_fall;
  logic                   w_pulse_nxt;
  logic                   r_level;
  logic                   r_pulse;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + C_ONE;

  // Plain flop chain for the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  // FSM state and filter counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and commit decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_commit_rise = 1'b0;
    w_commit_fall = 1'b0;
    case (r_state)
      ST_LO: begin
        w_cnt_nxt = '0;
        if (w_s) begin
          if (FILT_LEN == 1) begin
            w_state_nxt   = ST_HI;
            w_commit_rise = 1'b1;
          end else begin
            w_state_nxt = ST_CHK_HI;
            w_cnt_nxt   = C_ONE;
          end
        end
      end
      ST_CHK_HI: begin
        if (!w_s) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == C_LAST) begin
          w_state_nxt   = ST_HI;
          w_cnt_nxt     = '0;
          w_commit_rise = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HI: begin
        w_cnt_nxt = '0;
        if (!w_s) begin
          if (FILT_LEN == 1) begin
            w_state_nxt   = ST_LO;
            w_commit_fall = 1'b1;
          end else begin
            w_state_nxt = ST_CHK_LO;
            w_cnt_nxt   = C_ONE;
          end
        end
      end
      ST_CHK_LO: begin
        if (w_s) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == C_LAST) begin
          w_state_nxt   = ST_LO;
          w_cnt_nxt     = '0;
          w_commit_fall = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Mode is looked at only on the commit edge, so changing it never pulses.
  assign w_pulse_nxt = (w_commit_rise && edge_en(i_mode, 1'b1)) ||
                       (w_commit_fall && edge_en(i_mode, 1'b0));

  // Registered level and single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      if (w_commit_rise)      r_level <= 1'b1;
      else if (w_commit_fall) r_level <= 1'b0;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

`ifdef EDGE_DETECT_STICKY_EN
  logic r_sticky;

  // Sticky flag rises with the pulse; a new pulse beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= 1'b0;
    else        r_sticky <= w_pulse_nxt || (r_sticky && !i_clr);
  end

  assign o_sticky = r_sticky;
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector top: parameter checks and per-channel instances.
// Optional feature macro: EDGE_DETECT_STICKY_EN (o_sticky / i_clr per channel).
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input logic              clk,
  input logic              rst_n,
  edge_detect_multi_if.slave bus
);

  if (CH < 1) begin : g_bad_ch
    $error("edge_detect_multi: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_detect_multi: SYNC_STAGES must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("edge_detect_multi: FILT_LEN must be >= 1");
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sig    (bus.i_sig[g]),
      .i_mode   (bus.i_mode[2*g +: 2]),
      .o_level  (bus.o_level[g]),
      .o_pulse  (bus.o_pulse[g])
`ifdef EDGE_DETECT_STICKY_EN
      ,
      .i_clr    (bus.i_clr[g]),
      .o_sticky (bus.o_sticky[g])
`endif
    );
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi with default parameters (CH=4, SYNC=2, FILT=3).
// Also exercises the sticky flags when EDGE_DETECT_STICKY_EN is defined.
module tb_edge_detect_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int pcnt [4];
  int last [4];
  int gap  [4];

  int base0;
  int base1;
  int base2;
  int base3;
  int base_all;

  edge_detect_multi_if #(.CH(4)) bus ();

  edge_detect_multi #(
    .CH          (4),
    .SYNC_STAGES (2),
    .FILT_LEN    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping on the inactive edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_pulse[i]) begin
        gap[i]  = cyc - last[i];
        last[i] = cyc;
        pcnt[i] = pcnt[i] + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int psum();
    return pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      pcnt[i] = 0;
      last[i] = 0;
      gap[i]  = 0;
    end
    bus.i_sig  = '0;
    bus.i_mode = '0;
`ifdef EDGE_DETECT_STICKY_EN
    bus.i_clr  = '0;
`endif
    rst_n = 1'b0;
    step(2);
    chk("rst_level", 32'(bus.o_level), 32'h0);
    chk("rst_pulse", 32'(bus.o_pulse), 32'h0);
`ifdef EDGE_DETECT_STICKY_EN
    chk("rst_sticky", 32'(bus.o_sticky), 32'h0);
`endif
    rst_n = 1'b1;
    step(2);

    // Clean rise on ch0, mode rise.
    bus.i_sig[0] = 1'b1;
    step(4);
    chk("t1_pre_level", 32'(bus.o_level), 32'h0);
    chk("t1_pre_pulse", 32'(bus.o_pulse), 32'h0);
    step(1);
    chk("t1_level", 32'(bus.o_level), 32'h1);
    chk("t1_pulse", 32'(bus.o_pulse), 32'h1);
`ifdef EDGE_DETECT_STICKY_EN
    chk("t1_sticky", 32'(bus.o_sticky), 32'h1);
`endif
    step(1);
    chk("t1_pulse_end", 32'(bus.o_pulse), 32'h0);
    chk("t1_level_hold", 32'(bus.o_level), 32'h1);

`ifdef EDGE_DETECT_STICKY_EN
    chk("st_persist", 32'(bus.o_sticky[0]), 32'h1);
    // Fall pulse in mode both, with a clear sampled on the same edge.
    bus.i_mode[1:0] = 2'b10;
    bus.i_sig[0]    = 1'b0;
    step(4);
    bus.i_clr[0] = 1'b1;
    step(1);
    bus.i_clr[0] = 1'b0;
    chk("st_set_pulse", 32'(bus.o_pulse[0]), 32'h1);
    chk("st_set_wins", 32'(bus.o_sticky[0]), 32'h1);
    step(1);
    chk("st_hold", 32'(bus.o_sticky[0]), 32'h1);
    bus.i_clr[0] = 1'b1;
    step(1);
    bus.i_clr[0] = 1'b0;
    chk("st_cleared", 32'(bus.o_sticky[0]), 32'h0);
    bus.i_mode[1:0] = 2'b00;
    chk("t1_pulses", 32'(pcnt[0]), 32'd2);
`else
    bus.i_sig[0] = 1'b0;
    step(6);
    chk("t1_pulses", 32'(pcnt[0]), 32'd1);
`endif
    chk("t1_fall_level", 32'(bus.o_level[0]), 32'h0);

    // Glitch of two samples on ch1 is rejected.
    base1 = pcnt[1];
    bus.i_sig[1] = 1'b1;
    step(2);
    bus.i_sig[1] = 1'b0;
    step(8);
    chk("glitch_level", 32'(bus.o_level[1]), 32'h0);
    chk("glitch_pulses", 32'(pcnt[1] - base1), 32'h0);

    // Three samples high is accepted; the fall commits silently in mode rise.
    bus.i_sig[1] = 1'b1;
    step(3);
    bus.i_sig[1] = 1'b0;
    step(2);
    chk("g3_level", 32'(bus.o_level[1]), 32'h1);
    chk("g3_pulse", 32'(bus.o_pulse), 32'h2);
    step(2);
    chk("g3_level_hold", 32'(bus.o_level[1]), 32'h1);
    step(1);
    chk("g3_fall_level", 32'(bus.o_level[1]), 32'h0);
    chk("g3_fall_pulse", 32'(bus.o_pulse), 32'h0);
    step(4);
    chk("g3_pulses", 32'(pcnt[1] - base1), 32'd1);

    // Square wave on ch2 in mode both, 8-cycle half periods.
    base2 = pcnt[2];
    bus.i_mode[5:4] = 2'b10;
    for (int k = 0; k < 6; k++) begin
      bus.i_sig[2] = ~bus.i_sig[2];
      step(8);
    end
    chk("sq_pulses", 32'(pcnt[2] - base2), 32'd6);
    chk("sq_gap", 32'(gap[2]), 32'd8);
    chk("sq_level", 32'(bus.o_level[2]), 32'h0);

    // Mode off: level follows, no pulses.
    base2 = pcnt[2];
    bus.i_mode[5:4] = 2'b11;
    bus.i_sig[2] = 1'b1;
    step(8);
    chk("off_level_hi", 32'(bus.o_level[2]), 32'h1);
    bus.i_sig[2] = 1'b0;
    step(8);
    chk("off_level_lo", 32'(bus.o_level[2]), 32'h0);
    chk("off_pulses", 32'(pcnt[2] - base2), 32'h0);

    // Changing mode on idle channels does not pulse.
    base_all = psum();
    bus.i_mode = 8'hAA;
    step(4);
    bus.i_mode = 8'h00;
    step(2);
    chk("mode_chg_pulses", 32'(psum() - base_all), 32'h0);

    // ch3 high through reset release.
    rst_n = 1'b0;
    bus.i_sig[3] = 1'b1;
    #1;
    chk("r3_rst_level", 32'(bus.o_level), 32'h0);
    step(3);
    rst_n = 1'b1;
    base3 = pcnt[3];
    step(4);
    chk("r3_pre_level", 32'(bus.o_level), 32'h0);
    chk("r3_pre_pulse", 32'(bus.o_pulse), 32'h0);
    step(1);
    chk("r3_level", 32'(bus.o_level), 32'h8);
    chk("r3_pulse", 32'(bus.o_pulse), 32'h8);
    step(1);
    chk("r3_pulse_end", 32'(bus.o_pulse), 32'h0);
    chk("r3_pulses", 32'(pcnt[3] - base3), 32'd1);

    // Reset in the middle of a filter count on ch0.
    bus.i_sig[0] = 1'b1;
    bus.i_sig[3] = 1'b0;
    step(3);
    base0 = pcnt[0];
    base3 = pcnt[3];
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(bus.o_level), 32'h0);
    chk("mid_rst_pulse", 32'(bus.o_pulse), 32'h0);
    bus.i_sig[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    chk("mid_rst_ch0_pulses", 32'(pcnt[0] - base0), 32'h0);
    chk("mid_rst_ch3_pulses", 32'(pcnt[3] - base3), 32'h0);
    chk("mid_rst_level_after", 32'(bus.o_level), 32'h0);

    // All four channels together in modes rise/fall/both/off.
    bus.i_mode = {2'b11, 2'b10, 2'b01, 2'b00};
    bus.i_sig  = 4'hF;
    step(4);
    chk("all_pre_pulse", 32'(bus.o_pulse), 32'h0);
    step(1);
    chk("all_rise_pulse", 32'(bus.o_pulse), 32'h5);
    chk("all_rise_level", 32'(bus.o_level), 32'hF);
    step(1);
    chk("all_rise_end", 32'(bus.o_pulse), 32'h0);
    step(2);
    bus.i_sig = 4'h0;
    step(5);
    chk("all_fall_pulse", 32'(bus.o_pulse), 32'h6);
    chk("all_fall_level", 32'(bus.o_level), 32'h0);
    step(1);
    chk("all_fall_end", 32'(bus.o_pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised multi-channel edge detector: the next generation of the single-channel rising-edge FSM.
- Each channel has:
  - a synchroniser for asynchronous inputs;
  - a glitch filter that requires the input to hold stable for a programmable number of samples;
  - a runtime-selectable edge mode: rise, fall, both or off.
- Emits one-cycle pulses plus a filtered level. Used on pushbuttons, external strobes and cross-domain status lines.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 3, consecutive identical synchronised samples required to accept a level change (>=1)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
i_sig  input  CH  raw per-channel inputs, asynchronous to clk
i_mode  input  2*CH  per-channel mode, channel n at [2n+1:2n]: 00 rise, 01 fall, 10 both, 11 off
o_level  output  CH  filtered, debounced level per channel
o_pulse  output  CH  one-cycle edge pulse per channel, registered
o_sticky  output  CH  (only with EDGE_DETECT_STICKY_EN) latched pulse flags
i_clr  input  CH  (only with EDGE_DETECT_STICKY_EN) per-bit clear of o_sticky

Behaviour:
- Reset (async, rst_n=0):
  - all synchroniser flops 0;
  - FSM in ST_LO;
  - filter counter 0;
  - o_level=0, o_pulse=0, o_sticky=0.
  - Release is taken on the next posedge.
- Synchroniser: SYNC_STAGES-flop chain per channel; its last stage is s[n]. No logic between stages.
- Per-channel FSM (one-hot, 4 states), counter cnt with width $clog2(FILT_LEN+1):
  - ST_LO: s=0 -> stay, cnt=0. s=1 -> if FILT_LEN==1 commit to ST_HI; else go to ST_CHK_HI with cnt=1.
  - ST_CHK_HI: s=0 -> ST_LO, cnt=0 (glitch rejected, no pulse). s=1 -> cnt+1; when cnt+1==FILT_LEN commit to ST_HI.
  - ST_HI / ST_CHK_LO: mirror of the above with polarities swapped.
  - Illegal or default state -> ST_LO.
- Commit:
  - o_level registers the new stable level on the committing edge.
  - o_pulse is high for exactly the following cycle, if the edge type is enabled by i_mode.
  - Rise pulses in modes 00 and 10; fall pulses in modes 01 and 10; no pulses in mode 11.
  - o_level tracks in every mode.
- Latency: count the edge that first captures i_sig as edge 1. The new o_level and o_pulse are visible after edge SYNC_STAGES+FILT_LEN; with defaults, after edge 5.
- Minimum spacing: two pulses on one channel are at least FILT_LEN cycles apart. Pulse width is always 1 cycle, even if the input stays high.
- Mode change:
  - Sampled combinationally at the commit edge; takes effect on the next commit.
  - Never alters FSM state, never creates a pulse by itself.
- Channels are fully independent. Simultaneous commits on several channels all pulse in the same cycle.
- Reset mid-filter aborts the count; no pulse is generated.
- Input already high at reset release: after the normal latency the channel commits to high and emits a rise pulse, if enabled. This is intended.
- No combinational path from any input to any output.

Optional Feature:
- Macro EDGE_DETECT_STICKY_EN.
- Defined:
  - adds ports o_sticky and i_clr;
  - o_sticky[n] is set on the cycle o_pulse[n] is high (registered, same cycle as the pulse);
  - it holds until i_clr[n]=1 is sampled;
  - set wins over a simultaneous clear;
  - reset value 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Decomposition:
- Package edge_detect_pkg:
  - mode encodings MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF;
  - one-hot state constants ST_LO, ST_CHK_HI, ST_HI, ST_CHK_LO.
- Sub-module edge_detect_ch:
  - one channel: synchroniser, FSM, counter, output regs, and the sticky bit when enabled;
  - instantiated CH times via generate in edge_detect_multi.
- Top-level is wiring plus parameter legality checks: CH>=1, SYNC_STAGES>=2, FILT_LEN>=1.

Test Plan:
- Defaults, mode 00, i_sig[0] rises between edges and stays high -> o_level[0]=1 and o_pulse[0]=1 after edge 5; o_pulse low again after edge 6; other channels quiet.
- Glitch: i_sig[1] high for 2 cycles then low (FILT_LEN=3) -> o_level[1] stays 0, no pulse. A 3-cycle high -> exactly one pulse, then one fall commit with no pulse in mode 00.
- Mode 10 on ch2, clean square wave with 8-cycle half-periods -> pulse on every edge, 8 cycles apart. Mode 11 -> no pulses while o_level still toggles.
- i_sig[3] held high through reset release -> single rise pulse after edge 5 post-release. Assert rst_n mid-filter -> outputs clear immediately, no pulse.
- All four channels rising in the same cycle with modes 00/01/10/11 -> pulses on ch0 and ch2 only, same cycle.
- With EDGE_DETECT_STICKY_EN:
  - pulse on ch0 -> o_sticky[0]=1 persists;
  - i_clr[0] in the same cycle as a new pulse -> stays 1;
  - i_clr[0] alone -> clears next cycle.
